// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: mult/multu/div/divu with fixed
// multi-cycle latency, single-cycle mthi/mtlo, and the HI/LO registers.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_next_q, hi_next_d;
    logic [31:0]   lo_next_q, lo_next_d;
    logic          dz_q, dz_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Products and a single magnitude divider shared by div and divu.
    // Signed division runs on magnitudes and re-applies the signs, which
    // also yields 0x80000000 for the -2^31 / -1 overflow case.
    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'h0, a} * {32'h0, b};
        sgn    = (op == OP_DIV);
        div_a  = (sgn && a[31]) ? (32'h0 - a) : a;
        div_b  = (sgn && b[31]) ? (32'h0 - b) : b;
        q_mag  = '0;
        r_mag  = '0;
        if (div_b != 32'h0) begin
            q_mag = div_a / div_b;
            r_mag = div_a % div_b;
        end
        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (32'h0 - q_mag) : q_mag;
                res_hi = a[31] ? (32'h0 - r_mag) : r_mag;
            end
            OP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    // Next-state: accept in IDLE, count down in RUN, commit on the last edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_next_d = hi_next_q;
        lo_next_d = lo_next_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            hi_next_d = res_hi;
                            lo_next_d = res_lo;
                            dz_d      = 1'b0;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_next_d = res_hi;
                            lo_next_d = res_lo;
                            dz_d      = (b == 32'h0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = hi_next_q;
                        lo_d = lo_next_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset that aborts any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_next_q <= '0;
            lo_next_q <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_next_q <= hi_next_d;
            lo_next_q <= lo_next_d;
            dz_q      <= dz_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: an arithmetic reference model compared
// every cycle, plus directed operations with hand-computed results.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchk = 0;
    int nerr = 0;
    bit armed = 1'b0;

    int          cyc = 0;
    int          m_done = 0;
    logic        m_pend = 1'b0;
    logic        m_dz = 1'b0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] m_rh = 32'h0;
    logic [31:0] m_rl = 32'h0;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        p = 0; q = 0; r = 0;
        case (o)
            3'd1: p = sx * sy;
            3'd2: p = ux * uy;
            3'd3: if (sy != 0) begin q = sx / sy; r = sx % sy; end
            3'd4: if (uy != 0) begin q = ux / uy; r = ux % uy; end
            default: p = 0;
        endcase
        if (o <= 3'd2) return p;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
        end else if (m_pend) begin
            if (cyc == m_done) begin
                m_pend <= 1'b0;
                if (!m_dz) begin
                    m_hi <= m_rh;
                    m_lo <= m_rl;
                end
            end
        end else if (start) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                {m_rh, m_rl} <= ref_calc(op, a, b);
                m_dz   <= (op >= 3'd3) && (b == 32'h0);
                m_pend <= 1'b1;
                m_done <= cyc + ((op <= 3'd2) ? 5 : 10);
            end else if (op == 3'd5) begin
                m_hi <= a;
            end else if (op == 3'd6) begin
                m_lo <= a;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_busy", {31'h0, busy}, {31'h0, m_pend});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'd0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        issue(3'd1, 32'hFFFFFFFD, 32'd5);
        chk("accept_nobusy_hi", hi, 32'h0);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        chk("mult_m1_hi", hi, 32'h0);
        chk("mult_m1_lo", lo, 32'h1);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h0);

        issue(3'd5, 32'h12345678, 32'h0);
        chk("mthi_busy", {31'h0, busy}, 32'h0);
        chk("mthi_hi", hi, 32'h12345678);
        issue(3'd6, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_busy", {31'h0, busy}, 32'h0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        issue(3'd4, 32'd100, 32'h0);
        wait_idle(n);
        chk("dz_cycles", n, 32'd10);
        chk("dz_hi", hi, 32'h12345678);
        chk("dz_lo", lo, 32'h9ABCDEF0);

        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(posedge clk); #1;
        op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        wait_idle(n);
        chk("ign_remaining", n, 32'd6);
        chk("ign_lo", lo, 32'd14);
        chk("ign_hi", hi, 32'd2);

        issue(3'd4, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (12) @(negedge clk);
        chk("abort_late_hi", hi, 32'h0);
        chk("abort_late_lo", lo, 32'h0);
        chk("abort_late_busy", {31'h0, busy}, 32'h0);

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit for the E stage of the pipelined MIPS core. It executes mult, multu, div and divu with fixed multi-cycle latency, and mthi/mtlo in a single cycle. It holds the architectural HI/LO registers. HI/LO reach the GRF through the mfhi/mflo writeback path, and busy drives the hazard unit's stall logic.

Parameters:
MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (>=1)
DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (>=1)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an MDU op; sampled on posedge
op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  input  32  rs operand (dividend / multiplicand / mthi/mtlo source)
b  input  32  rt operand (divisor / multiplier)
busy  output  1  long operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (sync, active-high) forces hi=0, lo=0, busy=0, counter=0 and clears latched results. Reset during an in-flight op aborts it; no late HI/LO update.
- States: IDLE, RUN. Counter width fits max(MULT_CYCLES, DIV_CYCLES).
- IDLE with start=1 and op in 1..4:
  - Compute the result from a, b at that edge and hold it in internal hi_next/lo_next; a and b need not stay stable afterwards.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - busy=1 from the cycle after the accepting edge.
- RUN: counter decrements each edge. On the edge where the counter reaches 0, hi/lo take hi_next/lo_next, busy falls, and the state returns to IDLE.
  - Total: busy is high for exactly N cycles and hi/lo change at edge t+N for an accept at edge t.
- busy is not asserted in the accept cycle itself. The hazard unit stalls on (start & op in 1..4) | busy. The bench must not rely on busy alone.
- IDLE with start=1, op=5: hi<=a at that edge. With op=6: lo<=a. busy stays 0.
- start with op 0 or 7: no effect.
- start=1 while RUN (any op, including mthi/mtlo): ignored. The in-flight op is unaffected and no queueing occurs. The pipeline must never do this; the unit defines it as a no-op anyway.
- mult: signed 32x32 -> 64-bit product, {hi,lo} = product.
- multu: the same operation, unsigned.
- div: signed, lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (b==0, div or divu): the op is accepted and busy runs the full DIV_CYCLES, but hi/lo keep their old values at completion.
- hi/lo are plain register outputs with no combinational path from a, b or start.

Test Plan:
- Reset, then start op=1 a=0xFFFFFFFD b=5. Expect busy=1 for exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at edge t+5; hi/lo unchanged (0) before that.
- op=2 a=b=0xFFFFFFFF. Expect hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles. Then op=1 with the same operands: expect hi=0, lo=1.
- op=3 a=0xFFFFFFF9 (-7) b=2. Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. Then op=3 a=0x80000000 b=0xFFFFFFFF: expect lo=0x80000000, hi=0.
- mthi a=0x12345678, then next cycle mtlo a=0x9ABCDEF0. Expect busy=0 throughout, hi=0x12345678 then lo=0x9ABCDEF0. Then op=4 a=100 b=0: busy runs 10 cycles and hi/lo are unchanged.
- Start op=3 a=100 b=7. In cycle 3 of busy, pulse op=5 a=0xDEAD and op=1: both ignored. Expect lo=14, hi=2 at edge t+10.
- Start op=4 a=100 b=7. Assert reset in busy cycle 4. Expect busy=0 and hi=lo=0 from the next cycle, with no update at t+10.
